pc_msg_deframer: RTL and testbench



---
 rtl/pc_msg_deframer_pkg.sv | 41 ++++
 rtl/pc_msg_timeout.sv | 47 ++++
 rtl/pc_msg_deframer.sv | 202 ++++++++++++++++++++
 tb/tb_pc_msg_deframer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_msg_deframer_pkg.sv
// pc_msg_deframer_pkg
// Shared definitions for the host message deframer:
//   - PC_MSG_WORDS : number of host words per message
//   - state_t      : deframer FSM states (COLLECT / HOLD)
//   - cls_t        : message classification codes (BAD / START / STOP)
//   - STOP_FILL    : bit value filling every word of a STOP message
//   - classify()   : maps the STOP / START pattern matches onto a cls_t code
package pc_msg_deframer_pkg;

  localparam int         PC_MSG_WORDS = 3;
  localparam logic [1:0] IDX_FIRST    = 2'd0;
  localparam logic [1:0] IDX_LAST     = 2'(PC_MSG_WORDS - 1);

  // A STOP message is every bit of every word equal to this value.
  localparam logic       STOP_FILL    = 1'b0;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CLS_BAD   = 2'd0,
    CLS_START = 2'd1,
    CLS_STOP  = 2'd2
  } cls_t;

  // STOP has priority: an all-zero message can never also look like START,
  // but keeping the order explicit documents the intent.
  function automatic cls_t classify(input logic stop_match, input logic start_match);
    cls_t cls;
    cls = CLS_BAD;
    if (stop_match) begin
      cls = CLS_STOP;
    end else if (start_match) begin
      cls = CLS_START;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pc_msg_timeout.sv
// pc_msg_timeout
// Loadable up-counter with clear, count enable and a terminal-count pulse.
// The count restarts from zero on the terminal cycle so a single pulse is
// produced per run of LIMIT enabled cycles.
// Ports:
//   clk        in   counter clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous clear (highest priority)
//   load       in   load load_value into the counter
//   load_value in   WIDTH value used by load
//   enable     in   count one step
//   tc         out  combinational pulse on the enabled cycle at LIMIT-1
module pc_msg_timeout #(
  parameter int WIDTH = 11,
  parameter int LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // The pulse is suppressed whenever the count is being overridden, so a
  // clear in the same cycle always wins over an expiring count.
  assign tc = enable && !clear && !load && (count == TERMINAL);

  // Counter register: clear and terminal both restart from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_msg_deframer.sv
// pc_msg_deframer
// Pops 32-bit host words from a first-word-fall-through FIFO, assembles
// 3-word messages, classifies them as START / STOP / BAD and presents one
// command per good message over a valid/ready handshake. A partial message
// left idle for TIMEOUT cycles is discarded so the stream resynchronises.
// Optional build macro: PC_MSG_ECHO_EN adds a write-only echo of every
// popped word (echo_valid / echo_data / echo_full / echo_overflow).
// Ports:
//   CLK, RESET_N       clock, asynchronous active-low reset
//   pc_msg_valid       FIFO not empty
//   pc_msg             FIFO head word
//   pc_msg_ack         FIFO pop, combinational
//   cmd_valid/ready    command handshake
//   cmd_start/stop     command type
//   cmd_w0/w1/w2       message words in arrival order (w2 is an IEEE-754 float)
//   msg_count          accepted commands, wraps
//   err_count          BAD messages plus timeouts, saturates at 255
module pc_msg_deframer
  import pc_msg_deframer_pkg::*;
#(
  parameter int XB_SIZE = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               pc_msg_valid,
  input  logic [XB_SIZE-1:0] pc_msg,
  output logic               pc_msg_ack,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_start,
  output logic               cmd_stop,
  output logic [XB_SIZE-1:0] cmd_w0,
  output logic [XB_SIZE-1:0] cmd_w1,
  output logic [XB_SIZE-1:0] cmd_w2,
  output logic [15:0]        msg_count,
  output logic [7:0]         err_count
`ifdef PC_MSG_ECHO_EN
  ,
  output logic               echo_valid,
  output logic [XB_SIZE-1:0] echo_data,
  input  logic               echo_full,
  output logic               echo_overflow
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int HALF  = XB_SIZE / 2;

  state_t             state;
  state_t             state_next;
  logic [1:0]         word_idx;
  logic [XB_SIZE-1:0] slot0;
  logic [XB_SIZE-1:0] slot1;
  logic               word_last;
  logic               stop_match;
  logic               start_match;
  cls_t               msg_cls;
  logic               handshake;
  logic               tmo_clear;
  logic               tmo_enable;
  logic               tmo_tc;
  logic               timeout_fire;
  logic               err_event;

  // Words are only taken while collecting, so a held command stalls the FIFO
  // instead of being overwritten.
  assign pc_msg_ack = pc_msg_valid && (state == ST_COLLECT);
  assign word_last  = pc_msg_ack && (word_idx == IDX_LAST);
  assign handshake  = cmd_valid && cmd_ready;

  // The third word is still on the FIFO head when the message completes, so
  // classification looks at the two stored slots plus the live head word.
  always_comb begin
    stop_match  = (slot0  == {XB_SIZE{STOP_FILL}}) &&
                  (slot1  == {XB_SIZE{STOP_FILL}}) &&
                  (pc_msg == {XB_SIZE{STOP_FILL}});
    start_match = (pc_msg != '0) && (slot1[XB_SIZE-1 -: HALF] != '0);
    msg_cls     = classify(stop_match, start_match);
  end

  // Idle timer only runs mid-message with nothing to pop; any pop restarts it.
  assign tmo_clear  = pc_msg_ack || (word_idx == IDX_FIRST);
  assign tmo_enable = (word_idx != IDX_FIRST) && !pc_msg_valid;

  pc_msg_timeout #(
    .WIDTH (TMO_W),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clear      (tmo_clear),
    .load       (1'b0),
    .load_value ({TMO_W{1'b0}}),
    .enable     (tmo_enable),
    .tc         (tmo_tc)
  );

  assign timeout_fire = tmo_tc && !pc_msg_ack;
  assign err_event    = (word_last && (msg_cls == CLS_BAD)) || timeout_fire;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // A BAD message never reaches HOLD; a good one waits there for the handshake.
  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: begin
        if (word_last && (msg_cls != CLS_BAD)) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          state_next = ST_COLLECT;
        end
      end
      default: state_next = ST_COLLECT;
    endcase
  end

  // Word collection, idle discard and the registered command outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      word_idx  <= IDX_FIRST;
      slot0     <= '0;
      slot1     <= '0;
      cmd_valid <= 1'b0;
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
      cmd_w0    <= '0;
      cmd_w1    <= '0;
      cmd_w2    <= '0;
      msg_count <= '0;
      err_count <= '0;
    end else begin
      if (pc_msg_ack) begin
        if (word_idx == IDX_FIRST) begin
          slot0 <= pc_msg;
        end
        if (word_idx == 2'd1) begin
          slot1 <= pc_msg;
        end
        word_idx <= (word_idx == IDX_LAST) ? IDX_FIRST : word_idx + 2'd1;
      end else if (timeout_fire) begin
        word_idx <= IDX_FIRST;
        slot0    <= '0;
        slot1    <= '0;
      end

      if (word_last && (msg_cls != CLS_BAD)) begin
        cmd_valid <= 1'b1;
        cmd_start <= (msg_cls == CLS_START);
        cmd_stop  <= (msg_cls == CLS_STOP);
        cmd_w0    <= slot0;
        cmd_w1    <= slot1;
        cmd_w2    <= pc_msg;
      end

      if (handshake) begin
        cmd_valid <= 1'b0;
        cmd_start <= 1'b0;
        cmd_stop  <= 1'b0;
        msg_count <= msg_count + 16'd1;
      end

      if (err_event && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

`ifdef PC_MSG_ECHO_EN
  // Echo is a best-effort tap: a full sink loses the word and latches the
  // overflow flag, but never stalls the main path.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      echo_valid    <= 1'b0;
      echo_data     <= '0;
      echo_overflow <= 1'b0;
    end else begin
      echo_valid <= 1'b0;
      if (pc_msg_ack) begin
        if (echo_full) begin
          echo_overflow <= 1'b1;
        end else begin
          echo_valid <= 1'b1;
          echo_data  <= pc_msg;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_msg_deframer.sv
// tb_pc_msg_deframer
// Drives pc_msg_deframer from a queue-based FWFT FIFO model, issues directed
// and randomized messages, and checks decoded commands through a scoreboard
// whose expectations come from a message-level reference classifier.
module tb_pc_msg_deframer;

  localparam int XB  = 32;
  localparam int TMO = 1024;

  typedef struct packed {
    logic          start;
    logic          stop;
    logic [XB-1:0] w0;
    logic [XB-1:0] w1;
    logic [XB-1:0] w2;
  } cmd_t;

  logic          CLK;
  logic          RESET_N;
  logic          pc_msg_valid;
  logic [XB-1:0] pc_msg;
  logic          pc_msg_ack;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_start;
  logic          cmd_stop;
  logic [XB-1:0] cmd_w0;
  logic [XB-1:0] cmd_w1;
  logic [XB-1:0] cmd_w2;
  logic [15:0]   msg_count;
  logic [7:0]    err_count;
`ifdef PC_MSG_ECHO_EN
  logic          echo_valid;
  logic [XB-1:0] echo_data;
  logic          echo_full;
  logic          echo_overflow;
  logic [XB-1:0] echo_seen[$];
  logic [XB-1:0] echo_mark;
  bit            echo_test_en;
`endif

  logic [XB-1:0] fifo_q[$];
  cmd_t          exp_q[$];
  int            n_cmp;
  int            n_bad;
  int            exp_err;
  int            exp_msg;
  int            rdy_mode;
  bit            ack_seen;

  pc_msg_deframer #(
    .XB_SIZE (XB),
    .TIMEOUT (TMO)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .pc_msg_valid  (pc_msg_valid),
    .pc_msg        (pc_msg),
    .pc_msg_ack    (pc_msg_ack),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .cmd_w0        (cmd_w0),
    .cmd_w1        (cmd_w1),
    .cmd_w2        (cmd_w2),
    .msg_count     (msg_count),
    .err_count     (err_count)
`ifdef PC_MSG_ECHO_EN
    ,
    .echo_valid    (echo_valid),
    .echo_data     (echo_data),
    .echo_full     (echo_full),
    .echo_overflow (echo_overflow)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference classification straight from the message rules.
  function automatic int ref_kind(input logic [XB-1:0] a, input logic [XB-1:0] b, input logic [XB-1:0] c);
    if (a == 0 && b == 0 && c == 0) return 2;
    if (c != 0 && (b >> 16) != 0) return 1;
    return 0;
  endfunction

  function automatic void bump_err();
    if (exp_err < 255) exp_err++;
  endfunction

  task automatic pushWord(input logic [XB-1:0] w);
    @(posedge CLK);
    #1;
    fifo_q.push_back(w);
  endtask

  // gap < 0 pushes all three words at once; otherwise gap idle cycles between words.
  task automatic applyStimulus(input logic [XB-1:0] a, input logic [XB-1:0] b,
                               input logic [XB-1:0] c, input int gap);
    cmd_t e;
    int   k;
    k = ref_kind(a, b, c);
    if (k == 0) begin
      bump_err();
    end else begin
      e.start = (k == 1);
      e.stop  = (k == 2);
      e.w0 = a; e.w1 = b; e.w2 = c;
      exp_q.push_back(e);
    end
    if (gap < 0) begin
      @(posedge CLK);
      #1;
      fifo_q.push_back(a);
      fifo_q.push_back(b);
      fifo_q.push_back(c);
    end else begin
      repeat (gap) @(posedge CLK);
      pushWord(a);
      repeat (gap) @(posedge CLK);
      pushWord(b);
      repeat (gap) @(posedge CLK);
      pushWord(c);
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || cmd_valid) && cyc < 4000) begin
      @(negedge CLK);
      cyc++;
    end
    repeat (4) @(negedge CLK);
    checkOutput("drain_done", 64'(cyc < 4000), 64'd1);
  endtask

  // FWFT FIFO model: pop on an observed ack, then present the new head.
  initial begin
    logic [XB-1:0] junk;
    pc_msg_valid = 1'b0;
    pc_msg       = '0;
`ifdef PC_MSG_ECHO_EN
    echo_full    = 1'b0;
`endif
    forever begin
      @(posedge CLK);
      #1;
      if (ack_seen && fifo_q.size() > 0) junk = fifo_q.pop_front();
      #1;
      pc_msg_valid = (fifo_q.size() != 0);
      pc_msg       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
`ifdef PC_MSG_ECHO_EN
      echo_full    = echo_test_en && (fifo_q.size() != 0) && (fifo_q[0] == echo_mark);
`endif
    end
  end

  always @(negedge CLK) ack_seen = pc_msg_ack && RESET_N;

  // Application ready: 0 = always ready, 1 = stalled, otherwise random.
  initial begin
    cmd_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = 1'b0;
        default: cmd_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Scoreboard monitor: every accepted command is matched against the queue head.
  always @(negedge CLK) begin
    cmd_t e;
    if (RESET_N && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_cmd: got w0=0x%0h w1=0x%0h w2=0x%0h, expected no command",
                 cmd_w0, cmd_w1, cmd_w2);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_start", 64'(cmd_start), 64'(e.start));
        checkOutput("sb_stop",  64'(cmd_stop),  64'(e.stop));
        checkOutput("sb_w0",    64'(cmd_w0),    64'(e.w0));
        checkOutput("sb_w1",    64'(cmd_w1),    64'(e.w1));
        checkOutput("sb_w2",    64'(cmd_w2),    64'(e.w2));
        exp_msg++;
      end
    end
  end

`ifdef PC_MSG_ECHO_EN
  always @(negedge CLK) begin
    if (RESET_N && echo_test_en && echo_valid) echo_seen.push_back(echo_data);
  end
`endif

  initial begin
    int acks;
    int cyc;
    logic [XB-1:0] a;
    logic [XB-1:0] b;
    logic [XB-1:0] c;
    n_cmp = 0; n_bad = 0; exp_err = 0; exp_msg = 0; rdy_mode = 0;
`ifdef PC_MSG_ECHO_EN
    echo_test_en = 1'b0;
    echo_mark    = 32'h0012_0000;
`endif
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_cmd_valid", 64'(cmd_valid),  64'd0);
    checkOutput("rst_cmd_start", 64'(cmd_start),  64'd0);
    checkOutput("rst_cmd_stop",  64'(cmd_stop),   64'd0);
    checkOutput("rst_ack",       64'(pc_msg_ack), 64'd0);
    checkOutput("rst_msg_count", 64'(msg_count),  64'd0);
    checkOutput("rst_err_count", 64'(err_count),  64'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // START example, ready high: one-cycle latency after the third pop.
    $display("[TB] start message");
    applyStimulus(32'h0000_0140, 32'h0012_0000, 32'h3c23_d70a, -1);
    acks = 0;
    cyc  = 0;
    while (acks < 3 && cyc < 50) begin
      @(negedge CLK);
      if (pc_msg_ack) acks++;
      cyc++;
    end
    checkOutput("start_three_pops", 64'(acks), 64'd3);
    @(negedge CLK);
    checkOutput("start_valid",  64'(cmd_valid), 64'd1);
    checkOutput("start_flag",   64'(cmd_start), 64'd1);
    checkOutput("start_w1",     64'(cmd_w1),    64'h0012_0000);
    @(negedge CLK);
    checkOutput("start_pulse_end", 64'(cmd_valid), 64'd0);
    checkOutput("start_msg_count", 64'(msg_count), 64'd1);
    drain();

    // STOP held under backpressure with another message queued behind it.
    $display("[TB] stop held");
    rdy_mode = 1;
    @(negedge CLK);
    applyStimulus(32'h0, 32'h0, 32'h0, -1);
    applyStimulus(32'h0000_0200, 32'h0abc_0001, 32'h4049_0fdb, -1);
    cyc = 0;
    while (!cmd_valid && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    repeat (10) begin
      checkOutput("hold_valid", 64'(cmd_valid),  64'd1);
      checkOutput("hold_stop",  64'(cmd_stop),   64'd1);
      checkOutput("hold_start", 64'(cmd_start),  64'd0);
      checkOutput("hold_ack",   64'(pc_msg_ack), 64'd0);
      @(negedge CLK);
    end
    rdy_mode = 0;
    drain();

    // BAD message (w1 upper half zero) followed by STOP.
    $display("[TB] bad message");
    applyStimulus(32'h0000_0940, 32'h0, 32'h3c23_d70a, -1);
    applyStimulus(32'h0, 32'h0, 32'h0, -1);
    drain();
    checkOutput("bad_err_count", 64'(err_count), 64'(exp_err));
    checkOutput("bad_msg_count", 64'(msg_count), 64'(exp_msg));

    // Partial message abandoned for longer than the timeout.
    $display("[TB] timeout");
    pushWord(32'h0000_0140);
    repeat (TMO + 20) @(negedge CLK);
    bump_err();
    checkOutput("tmo_err_count", 64'(err_count), 64'(exp_err));
    applyStimulus(32'h0000_0140, 32'h0012_0000, 32'h3c23_d70a, -1);
    drain();
    // A long but sub-timeout gap must not discard the message.
    applyStimulus(32'h0000_0777, 32'h5500_0000, 32'h3f80_0000, -2);
    fifo_q.delete();
    pushWord(32'h0000_0777);
    repeat (TMO - 40) @(posedge CLK);
    pushWord(32'h5500_0000);
    pushWord(32'h3f80_0000);
    drain();
    checkOutput("gap_err_count", 64'(err_count), 64'(exp_err));

    // Reset in the middle of a message.
    $display("[TB] reset mid-message");
    pushWord(32'h0000_0140);
    pushWord(32'h0012_0000);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    exp_err = 0;
    exp_msg = 0;
    repeat (2) @(negedge CLK);
    checkOutput("mid_rst_valid", 64'(cmd_valid),  64'd0);
    checkOutput("mid_rst_ack",   64'(pc_msg_ack), 64'd0);
    checkOutput("mid_rst_w0",    64'(cmd_w0),     64'd0);
    checkOutput("mid_rst_w2",    64'(cmd_w2),     64'd0);
    checkOutput("mid_rst_msgs",  64'(msg_count),  64'd0);
    checkOutput("mid_rst_errs",  64'(err_count),  64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    applyStimulus(32'h0, 32'h0, 32'h0, -1);
    drain();
    checkOutput("post_rst_msgs", 64'(msg_count), 64'(exp_msg));

    // Randomized traffic under random backpressure.
    $display("[TB] random traffic");
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      b = ($urandom_range(3) == 0) ? {16'h0, 16'($urandom)} : $urandom;
      c = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(5) == 0) begin
        a = 32'h0; b = 32'h0; c = 32'h0;
      end
      applyStimulus(a, b, c, int'($urandom_range(4)) - 1);
    end
    rdy_mode = 0;
    drain();
    checkOutput("rand_msg_count", 64'(msg_count), 64'(exp_msg % 65536));
    checkOutput("rand_err_count", 64'(err_count), 64'(exp_err));

    // Enough BAD messages to saturate the error counter.
    $display("[TB] error saturation");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(32'h1, 32'h0, 32'h0, 0);
    end
    drain();
    checkOutput("sat_err_count", 64'(err_count), 64'(exp_err));
    checkOutput("sat_err_limit", 64'(err_count), 64'd255);

`ifdef PC_MSG_ECHO_EN
    // Echo sink full while the second word is popped.
    $display("[TB] echo overflow");
    checkOutput("echo_ovf_clear", 64'(echo_overflow), 64'd0);
    echo_seen.delete();
    echo_test_en = 1'b1;
    applyStimulus(32'h0000_0140, 32'h0012_0000, 32'h3c23_d70a, -1);
    drain();
    echo_test_en = 1'b0;
    checkOutput("echo_count", 64'(echo_seen.size()), 64'd2);
    if (echo_seen.size() == 2) begin
      checkOutput("echo_word1", 64'(echo_seen[0]), 64'h0000_0140);
      checkOutput("echo_word3", 64'(echo_seen[1]), 64'h3c23_d70a);
    end
    checkOutput("echo_ovf_set", 64'(echo_overflow), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
